// File: rtl/div_iter_unit_pkg.sv
// Shared types for the mul/div slot: ALU opcode set, divider FSM states,
// and the signed-op helper used by the iterative divider.
package div_iter_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_type;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int DIV_MAX_BPC = 4;

    function automatic logic is_signed_div(alu_op_type op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/div_iter_unit_step_array.sv
// Combinational restoring-division slice: BPC chained shift/compare/subtract
// stages, consuming dividend bits MSB-first and producing one quotient bit each.
module div_step_array #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [BPC-1:0]  dvd_bits,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [BPC-1:0]  q_bits
);

    logic [BPC:0][XLEN-1:0] r;

    assign r[0] = rem_in;

    for (genvar i = 0; i < BPC; i++) begin : g_stage
        // The shifted remainder needs one extra bit before the compare.
        logic [XLEN:0] sh;
        assign sh                 = {r[i], dvd_bits[BPC-1-i]};
        assign q_bits[BPC-1-i]    = (sh >= {1'b0, divisor});
        assign r[i+1]             = q_bits[BPC-1-i] ? XLEN'(sh - {1'b0, divisor})
                                                    : sh[XLEN-1:0];
    end

    assign rem_out = r[BPC];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative DIV/DIVU/REM/REMU unit retiring BITS_PER_CYCLE quotient bits per cycle.
// Build option: DIV_EARLY_OUT_EN skips leading-zero dividend bits at accept.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_type       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = XLEN / B;
    localparam int CNT_W = $clog2(N + 1);

    div_state_t       state;
    alu_op_type       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  abs_b, dvd, rem;
    logic [CNT_W-1:0] cnt;

    alu_op_type       op_n;
    logic             a_neg_n, b_neg_n;
    logic [XLEN-1:0]  abs_a_n, abs_b_n, dvd_init, zero_res;
    logic [CNT_W-1:0] cnt_init;

    always_comb begin
        case (in_op)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: op_n = in_op;
            default:                             op_n = ALU_DIVU;
        endcase
        a_neg_n  = is_signed_div(op_n) & in_a[XLEN-1];
        b_neg_n  = is_signed_div(op_n) & in_b[XLEN-1];
        abs_a_n  = a_neg_n ? -in_a : in_a;
        abs_b_n  = b_neg_n ? -in_b : in_b;
        zero_res = (op_n == ALU_DIV || op_n == ALU_DIVU) ? '1 : in_a;
    end

`ifdef DIV_EARLY_OUT_EN
    // Preshift by whole B-bit groups of leading zeros; the skipped iterations
    // would only have shifted zeros into the remainder.
    always_comb begin
        int lz, sh;
        lz = XLEN;
        for (int i = 0; i < XLEN; i++)
            if (abs_a_n[i]) lz = XLEN - 1 - i;
        sh       = (lz / B) * B;
        dvd_init = abs_a_n << sh;
        cnt_init = (sh / B >= N) ? CNT_W'(1) : CNT_W'(N - sh / B);
    end
`else
    assign dvd_init = abs_a_n;
    assign cnt_init = CNT_W'(N);
`endif

    logic [XLEN-1:0] rem_nxt, q_fin, res_fin;
    logic [B-1:0]    q_bits;

    div_step_array #(.XLEN(XLEN), .BPC(B)) u_step (
        .rem_in   (rem),
        .dvd_bits (dvd[XLEN-1 -: B]),
        .divisor  (abs_b),
        .rem_out  (rem_nxt),
        .q_bits   (q_bits)
    );

    // Quotient bits refill the dividend register from the bottom as it empties.
    assign q_fin = {dvd[XLEN-B-1:0], q_bits};

    always_comb begin
        case (op_q)
            ALU_DIV:  res_fin = (a_neg ^ b_neg) ? -q_fin : q_fin;
            ALU_REM:  res_fin = a_neg ? -rem_nxt : rem_nxt;
            ALU_REMU: res_fin = rem_nxt;
            default:  res_fin = q_fin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= ALU_ADD;
            tag_q      <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            abs_b      <= '0;
            dvd        <= '0;
            rem        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= op_n;
                    tag_q <= in_tag;
                    if (in_b == '0) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= zero_res;
                        out_tag    <= in_tag;
                    end else begin
                        state <= CALC;
                        a_neg <= a_neg_n;
                        b_neg <= b_neg_n;
                        abs_b <= abs_b_n;
                        dvd   <= dvd_init;
                        rem   <= '0;
                        cnt   <= cnt_init;
                    end
                end
                CALC: begin
                    dvd <= q_fin;
                    rem <= rem_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= res_fin;
                        out_tag    <= tag_q;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed + scoreboard bench for div_iter_unit at B=1, 2 and 4.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, out_ready;
    alu_op_type  in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic [2:0]  vin, rdy, vout, bsy;
    logic [2:0][31:0] res;
    logic [2:0][3:0]  tgo;

    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(vin[0]), .in_ready(rdy[0]),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vout[0]),
        .out_ready(out_ready), .out_result(res[0]), .out_tag(tgo[0]), .busy(bsy[0]));
    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(2), .TAG_W(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(vin[1]), .in_ready(rdy[1]),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vout[1]),
        .out_ready(out_ready), .out_result(res[1]), .out_tag(tgo[1]), .busy(bsy[1]));
    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(vin[2]), .in_ready(rdy[2]),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(vout[2]),
        .out_ready(out_ready), .out_result(res[2]), .out_tag(tgo[2]), .busy(bsy[2]));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    alu_op_type ops[4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // RISC-V M reference semantics.
    function automatic logic [31:0] model(alu_op_type op, logic [31:0] a, logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFF_FFFF : a;
        case (op)
            ALU_DIV:  return ovf ? a     : 32'($signed(a) / $signed(b));
            ALU_REM:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            ALU_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic int exp_lat(int k, alu_op_type op, logic [31:0] a, logic [31:0] b);
        int bp, n;
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] aa;
        int lz, s, c;
`endif
        bp = 1 << k;
        n  = 32 / bp;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        aa = (is_signed_div(op) && a[31]) ? -a : a;
        lz = 32;
        for (int i = 31; i >= 0; i--)
            if (aa[i] && lz == 32) lz = 31 - i;
        s = (lz / bp) * bp;
        c = n - s / bp;
        if (c < 1) c = 1;
        return c + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic start(input int k, input alu_op_type op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        @(negedge clk);
        chk($sformatf("in_ready_%0d", k), 32'(rdy[k]), 32'd1);
        in_op = op; in_a = a; in_b = b; in_tag = tag;
        vin[k] = 1'b1;
        @(posedge clk);
        #1 vin[k] = 1'b0;
    endtask

    task automatic collect(input int k);
        int   lat;
        exp_t e;
        lat = 1;
        @(negedge clk);
        while (vout[k] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL sb_pop: observed empty queue expected an entry");
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("lat_%0d", k), 32'(lat), 32'(e.lat));
            chk($sformatf("result_%0d", k), res[k], e.res);
            chk($sformatf("tag_%0d", k), 32'(tgo[k]), 32'(e.tag));
        end
        @(posedge clk);
    endtask

    task automatic run(input int k, input alu_op_type op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input logic [31:0] r);
        exp_t e;
        e.res = r; e.tag = tag; e.lat = exp_lat(k, op, a, b);
        sb.push_back(e);
        start(k, op, a, b, tag);
        collect(k);
    endtask

    initial begin
        logic [31:0] ra, rb;
        alu_op_type  rop;
        logic        seen;
        int          w;

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1; vin = '0;
        in_op = ALU_DIVU; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(vout[0]), 32'd0);
        chk("rst_out_result", res[0], 32'd0);
        chk("rst_out_tag", 32'(tgo[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(rdy[0]), 32'd1);

        // signed and unsigned basics, all three widths
        run(0, ALU_DIV,  32'hFFFF_FFF9, 32'd2, 4'd1, 32'hFFFF_FFFD);
        run(0, ALU_REM,  32'hFFFF_FFF9, 32'd2, 4'd2, 32'hFFFF_FFFF);
        run(0, ALU_DIVU, 32'd100, 32'd7, 4'd3, 32'd14);
        run(0, ALU_REMU, 32'd100, 32'd7, 4'd4, 32'd2);
        run(1, ALU_DIVU, 32'd100, 32'd7, 4'd5, 32'd14);
        run(1, ALU_REMU, 32'd100, 32'd7, 4'd6, 32'd2);
        run(2, ALU_DIVU, 32'd100, 32'd7, 4'd7, 32'd14);
        run(2, ALU_REMU, 32'd100, 32'd7, 4'd8, 32'd2);

        // divide by zero and signed overflow
        run(0, ALU_DIV,  32'h1234, 32'd0, 4'd9,  32'hFFFF_FFFF);
        run(0, ALU_REM,  32'h1234, 32'd0, 4'd10, 32'h1234);
        run(2, ALU_DIVU, 32'h55,   32'd0, 4'd11, 32'hFFFF_FFFF);
        run(1, ALU_REMU, 32'h55,   32'd0, 4'd12, 32'h55);
        run(0, ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 32'h8000_0000);
        run(0, ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 32'd0);
        run(2, ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'd15, 32'h8000_0000);

        // short dividends (latency depends on the early-out build)
        run(0, ALU_DIVU, 32'd5, 32'd1, 4'd1, 32'd5);
        run(0, ALU_DIVU, 32'd0, 32'd7, 4'd2, 32'd0);
        run(1, ALU_REM,  32'd0, 32'hFFFF_FFFD, 4'd3, 32'd0);

        // random operands against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = ops[$urandom_range(0, 3)];
            ra  = $urandom;
            if (i % 3 == 0) ra = $urandom_range(0, 300);
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run(i % 3, rop, ra, rb, 4'(i), model(rop, ra, rb));
        end

        // backpressure holds the result
        out_ready = 1'b0;
        start(0, ALU_DIVU, 32'd100, 32'd7, 4'd9);
        w = 0;
        @(negedge clk);
        while (vout[0] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("bp_reached_done", 32'(vout[0]), 32'd1);
        repeat (10) begin
            chk("bp_valid", 32'(vout[0]), 32'd1);
            chk("bp_result", res[0], 32'd14);
            chk("bp_tag", 32'(tgo[0]), 32'd9);
            chk("bp_in_ready", 32'(rdy[0]), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(vout[0]), 32'd0);
        chk("bp_release_ready", 32'(rdy[0]), 32'd1);

        // flush during CALC
        start(0, ALU_DIV, 32'd1000, 32'd7, 4'd2);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vout[0] === 1'b1) seen = 1'b1;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        chk("flush_busy", 32'(bsy[0]), 32'd0);
        run(0, ALU_DIVU, 32'd9, 32'd3, 4'd5, 32'd3);

        // flush coincident with a request drops it
        @(negedge clk);
        in_op = ALU_DIVU; in_a = 32'd9; in_b = 32'd3; in_tag = 4'd11;
        vin[0] = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin vin[0] = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_acc_ready", 32'(rdy[0]), 32'd1);
        chk("flush_acc_busy", 32'(bsy[0]), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vout[0] === 1'b1) seen = 1'b1;
        end
        chk("flush_acc_no_valid", 32'(seen), 32'd0);

        // reset mid-CALC
        start(0, ALU_DIVU, 32'd1000, 32'd3, 4'd7);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(vout[0]), 32'd0);
        chk("midrst_result", res[0], 32'd0);
        chk("midrst_tag", 32'(tgo[0]), 32'd0);
        chk("midrst_busy", 32'(bsy[0]), 32'd0);
        reset_n = 1'b1;
        run(0, ALU_REMU, 32'd1000, 32'd3, 4'd8, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
